// File: rtl/wide_adder_sequencer_pkg.sv
// Shared types and constants for the nibble-serial wide adder.
package wide_adder_sequencer_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int   SLICE_W = 4;
   localparam logic OP_ADD  = 1'b0;
   localparam logic OP_SUB  = 1'b1;

endpackage

// File: rtl/wide_adder_sequencer_rca.sv
// 4-bit ripple carry adder slice shared by every step of the sequencer.
module wide_adder_sequencer_rca
   import wide_adder_sequencer_pkg::*;
(
   input  logic [SLICE_W-1:0] in1,
   input  logic [SLICE_W-1:0] in2,
   input  logic               c_in,
   output logic [SLICE_W-1:0] sum,
   output logic               c_out
);

   logic c;

   always_comb begin
      sum = '0;
      c   = c_in;
      for (int i = 0; i < SLICE_W; i++) begin
         sum[i] = in1[i] ^ in2[i] ^ c;
         c      = (in1[i] & in2[i]) | (c & (in1[i] ^ in2[i]));
      end
      c_out = c;
   end

endmodule

// File: rtl/wide_adder_sequencer.sv
// WIDTH-bit add/sub stepped LSB-first through one 4-bit RCA slice,
// with a registered carry between nibbles and a done pulse at the end.
module wide_adder_sequencer
   import wide_adder_sequencer_pkg::*;
#(
   parameter int WIDTH = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             overflow
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int IW     = $clog2(NSLICE);
   localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

   state_t             state;
   state_t             state_nx;
   logic [IW-1:0]      idx;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               carry_q;
   logic [SLICE_W-1:0] s_in1;
   logic [SLICE_W-1:0] s_in2;
   logic [SLICE_W-1:0] s_sum;
   logic               s_co;
   logic               accept;
   logic               last;

   assign accept = start && (state != S_RUN);
   assign last   = (idx == LAST);
   assign s_in1  = a_q[idx*SLICE_W +: SLICE_W];
   assign s_in2  = b_q[idx*SLICE_W +: SLICE_W];

   wide_adder_sequencer_rca u_rca (
      .in1   (s_in1),
      .in2   (s_in2),
      .c_in  (carry_q),
      .sum   (s_sum),
      .c_out (s_co)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE:  if (start) state_nx = S_RUN;
         S_RUN:   if (last)  state_nx = S_DONE;
         S_DONE:  state_nx = start ? S_RUN : S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == S_RUN);
      done = (state == S_DONE);
   end

   // b is stored pre-inverted for subtract so the slice only ever adds
   always_ff @(posedge clk) begin
      if (rst) begin
         idx      <= '0;
         a_q      <= '0;
         b_q      <= '0;
         carry_q  <= 1'b0;
         result   <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else if (accept) begin
         idx      <= '0;
         a_q      <= a;
         b_q      <= (op == OP_SUB) ? ~b : b;
         carry_q  <= (op == OP_SUB) ? 1'b1 : c_in;
         result   <= '0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else if (state == S_RUN) begin
         result[idx*SLICE_W +: SLICE_W] <= s_sum;
         carry_q <= s_co;
         if (last) begin
            c_out    <= s_co;
            overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                        (s_sum[SLICE_W-1] != a_q[WIDTH-1]);
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wide_adder_sequencer.sv
// Self-checking bench for wide_adder_sequencer (WIDTH=16).
module tb_wide_adder_sequencer;

   localparam int WIDTH  = 16;
   localparam int NSLICE = WIDTH / 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        op;
   logic        c_in;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        c_out;
   logic        overflow;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wide_adder_sequencer #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .c_in     (c_in),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .c_out    (c_out),
      .overflow (overflow)
   );

   // Plain integer arithmetic: returns {overflow, c_out, result}
   function automatic logic [17:0] model(input logic [15:0] ma,
                                         input logic [15:0] mb,
                                         input logic mop,
                                         input logic mcin);
      int sa, sb, ua, ub, s, u;
      logic co, ov;
      sa = $signed(ma);
      sb = $signed(mb);
      ua = int'(ma);
      ub = int'(mb);
      if (mop) begin
         s  = sa - sb;
         u  = ua - ub;
         co = (ua >= ub);
      end else begin
         s  = sa + sb + int'(mcin);
         u  = ua + ub + int'(mcin);
         co = (u > 65535);
      end
      ov = (s > 32767) || (s < -32768);
      return {ov, co, u[15:0]};
   endfunction

   task automatic run_op(input logic [15:0] ia, input logic [15:0] ib,
                         input logic iop, input logic icin,
                         output logic [15:0] r, output logic co,
                         output logic ov, output int lat, output bit ok);
      @(negedge clk);
      a = ia; b = ib; op = iop; c_in = icin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0; ok = 1'b0; r = '0; co = 1'b0; ov = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            ok = 1'b1; r = result; co = c_out; ov = overflow;
            break;
         end
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 1'b0; c_in = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy got %b want 0", busy);
      end
      n_checks++;
      if (done !== 1'b0) begin
         n_fail++; $display("FAIL reset_done got %b want 0", done);
      end
      n_checks++;
      if ({overflow, c_out, result} !== 18'h0) begin
         n_fail++;
         $display("FAIL reset_outputs got ov=%b co=%b r=%h want 0",
                  overflow, c_out, result);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [15:0] ta [4] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005};
      logic [15:0] tb [4] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007};
      logic        to [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic [15:0] er [4] = '{16'h5555, 16'h0000, 16'h8000, 16'hFFFE};
      logic        ec [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic        eo [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [15:0] r;
      logic co, ov;
      int lat;
      bit ok;
      for (int i = 0; i < 4; i++) begin
         run_op(ta[i], tb[i], to[i], 1'b0, r, co, ov, lat, ok);
         n_checks++;
         if (!ok || lat != NSLICE) begin
            n_fail++;
            $display("FAIL directed%0d_latency got ok=%0d lat=%0d want %0d",
                     i, ok, lat, NSLICE);
         end
         n_checks++;
         if ({ov, co, r} !== {eo[i], ec[i], er[i]}) begin
            n_fail++;
            $display("FAIL directed%0d_result got r=%h co=%b ov=%b want r=%h co=%b ov=%b",
                     i, r, co, ov, er[i], ec[i], eo[i]);
         end
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0 || result !== er[i]) begin
            n_fail++;
            $display("FAIL directed%0d_hold got done=%b r=%h want done=0 r=%h",
                     i, done, result, er[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      @(negedge clk);
      a = 16'h1234; b = 16'h4321; op = 1'b0; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 16'hAAAA; b = 16'hFFFF; start = 1'b1;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL b2b_busy got %b want 1", busy);
      end
      @(negedge clk);
      start = 1'b0; a = '0; b = '0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (done !== 1'b1 || result !== 16'h5555) begin
         n_fail++;
         $display("FAIL b2b_ignored got done=%b r=%h want done=1 r=5555",
                  done, result);
      end
      a = 16'h0001; b = 16'h0002; c_in = 1'b1; op = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0 || result !== 16'h0000) begin
         n_fail++;
         $display("FAIL b2b_accept got busy=%b done=%b r=%h want 1 0 0000",
                  busy, done, result);
      end
      cyc = 1;
      while (!done && cyc < 12) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (!done || cyc != NSLICE + 1) begin
         n_fail++;
         $display("FAIL b2b_latency got done=%b cyc=%0d want %0d",
                  done, cyc, NSLICE + 1);
      end
      n_checks++;
      if ({overflow, c_out, result} !== {2'b00, 16'h0004}) begin
         n_fail++;
         $display("FAIL b2b_result got r=%h co=%b ov=%b want 0004 0 0",
                  result, c_out, overflow);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle got done=%b busy=%b want 0 0", done, busy);
      end
   endtask

   task automatic test_abort();
      bit seen;
      logic [17:0] e;
      logic [15:0] r;
      logic co, ov;
      int lat;
      bit ok;
      @(negedge clk);
      a = 16'hFFFF; b = 16'h0001; op = 1'b0; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 ||
          {overflow, c_out, result} !== 18'h0) begin
         n_fail++;
         $display("FAIL abort_clear got busy=%b done=%b r=%h co=%b ov=%b want all 0",
                  busy, done, result, c_out, overflow);
      end
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin
         n_fail++; $display("FAIL abort_no_done got done pulse want none");
      end
      e = model(16'h0F0F, 16'h1010, 1'b0, 1'b1);
      run_op(16'h0F0F, 16'h1010, 1'b0, 1'b1, r, co, ov, lat, ok);
      n_checks++;
      if (!ok || {ov, co, r} !== e) begin
         n_fail++;
         $display("FAIL abort_fresh got ok=%0d r=%h co=%b ov=%b want %h %b %b",
                  ok, r, co, ov, e[15:0], e[16], e[17]);
      end
   endtask

   task automatic test_random();
      logic [17:0] exp_q [$];
      logic [17:0] e;
      int acc = 0;
      int dn = 0;
      int since = 0;
      int gap = 0;
      int cyc = 0;
      bit outstanding = 1'b0;
      while ((acc < 500 || outstanding) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (outstanding) since++;
         if (done) begin
            dn++;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rand_spurious_done got done=1 want no pending op");
            end else begin
               e = exp_q.pop_front();
               if ({overflow, c_out, result} !== e || since != NSLICE + 1) begin
                  n_fail++;
                  $display("FAIL rand_op%0d got r=%h co=%b ov=%b lat=%0d want r=%h co=%b ov=%b lat=%0d",
                           dn, result, c_out, overflow, since,
                           e[15:0], e[16], e[17], NSLICE + 1);
               end
            end
            outstanding = 1'b0;
         end else if (outstanding && since > NSLICE + 3) begin
            n_checks++;
            n_fail++;
            $display("FAIL rand_timeout got no done after %0d cycles want %0d",
                     since, NSLICE + 1);
            outstanding = 1'b0;
            exp_q.delete();
         end
         start = 1'b0;
         a = 16'($urandom);
         b = 16'($urandom);
         op = 1'($urandom);
         c_in = 1'($urandom);
         if (!outstanding) begin
            if (gap == 0 && acc < 500) begin
               start = 1'b1;
               exp_q.push_back(model(a, b, op, c_in));
               outstanding = 1'b1;
               since = 0;
               acc++;
               gap = $urandom_range(0, 3);
            end else if (gap > 0) begin
               gap--;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            start = 1'b1;
         end
      end
      start = 1'b0;
      n_checks++;
      if (dn != acc || acc != 500) begin
         n_fail++;
         $display("FAIL rand_count got done=%0d accepted=%0d want 500 each", dn, acc);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_abort();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog got simulation still running want finished");
      $fatal(1, "watchdog expired");
   end

endmodule
